// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-flop sync, shared sample prescaler, per-key debounce
// and hold FSM producing press/release/long/repeat single-cycle pulses.

module key_conditioner_lane #(
  parameter int DEBOUNCE_SAMPLES = 16,
  parameter int LONG_SAMPLES     = 512,
  parameter int REPEAT_SAMPLES   = 128,
  parameter int ACTIVE_LOW       = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic down,
  output logic up,
  output logic long_pulse,
  output logic rpt_pulse
);
  localparam logic IDLE_RAW = (ACTIVE_LOW != 0);
  localparam int   DBW      = $clog2(DEBOUNCE_SAMPLES);
  localparam int   HMAX     = (LONG_SAMPLES > REPEAT_SAMPLES) ? LONG_SAMPLES : REPEAT_SAMPLES;
  localparam int   HW       = (HMAX > 1) ? $clog2(HMAX) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} hold_state_t;

  logic [1:0]     sync;
  logic           pressed_s;
  logic [DBW-1:0] db_cnt, db_nxt;
  logic           level_nxt;
  hold_state_t    state, state_nxt;
  logic [HW-1:0]  hold_cnt, hold_nxt;
  logic [HW:0]    hold_inc;
  logic           down_nxt, up_nxt, long_nxt, rpt_nxt;

  assign pressed_s = sync[1] ^ IDLE_RAW;
  assign hold_inc  = {1'b0, hold_cnt} + (HW+1)'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync       <= {2{IDLE_RAW}};
      level      <= 1'b0;
      db_cnt     <= '0;
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      down       <= 1'b0;
      up         <= 1'b0;
      long_pulse <= 1'b0;
      rpt_pulse  <= 1'b0;
    end else begin
      sync       <= {sync[0], raw};
      level      <= level_nxt;
      db_cnt     <= db_nxt;
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      down       <= down_nxt;
      up         <= up_nxt;
      long_pulse <= long_nxt;
      rpt_pulse  <= rpt_nxt;
    end
  end

  always_comb begin
    level_nxt = level;
    db_nxt    = db_cnt;
    state_nxt = state;
    hold_nxt  = hold_cnt;
    down_nxt  = 1'b0;
    up_nxt    = 1'b0;
    long_nxt  = 1'b0;
    rpt_nxt   = 1'b0;
    if (tick) begin
      if (pressed_s == level)
        db_nxt = '0;
      else if (db_cnt == DBW'(DEBOUNCE_SAMPLES-1)) begin
        level_nxt = ~level;
        db_nxt    = '0;
      end else
        db_nxt = db_cnt + DBW'(1);

      // A level flip consumes the tick, so it always beats long/repeat.
      if (level_nxt != level) begin
        down_nxt  = level_nxt;
        up_nxt    = ~level_nxt;
        state_nxt = level_nxt ? ST_HELD : ST_IDLE;
        hold_nxt  = '0;
      end else begin
        case (state)
          ST_HELD:
            if (hold_inc == (HW+1)'(LONG_SAMPLES)) begin
              long_nxt  = 1'b1;
              state_nxt = ST_LONG;
              hold_nxt  = '0;
            end else
              hold_nxt = hold_inc[HW-1:0];
          ST_LONG:
            if (hold_inc == (HW+1)'(REPEAT_SAMPLES)) begin
              rpt_nxt  = 1'b1;
              hold_nxt = '0;
            end else
              hold_nxt = hold_inc[HW-1:0];
          default: ;
        endcase
      end
    end
  end
endmodule

module key_conditioner #(
  parameter int NUM_KEYS         = 2,
  parameter int SAMPLE_DIV       = 1024,
  parameter int DEBOUNCE_SAMPLES = 16,
  parameter int LONG_SAMPLES     = 512,
  parameter int REPEAT_SAMPLES   = 128,
  parameter int ACTIVE_LOW       = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic                sample_tick,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_up,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);
  localparam int DIVW = $clog2(SAMPLE_DIV);

  logic [DIVW-1:0] div_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      div_cnt <= '0;
    else if (div_cnt == DIVW'(SAMPLE_DIV-1))
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + DIVW'(1);
  end

  assign sample_tick = (div_cnt == DIVW'(SAMPLE_DIV-1));

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
    key_conditioner_lane #(
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES),
      .LONG_SAMPLES    (LONG_SAMPLES),
      .REPEAT_SAMPLES  (REPEAT_SAMPLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_lane (
      .clock     (clock),
      .reset     (reset),
      .tick      (sample_tick),
      .raw       (key_raw[g]),
      .level     (key_level[g]),
      .down      (key_down[g]),
      .up        (key_up[g]),
      .long_pulse(key_long[g]),
      .rpt_pulse (key_repeat[g])
    );
  end
endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: vector table for press/release/glitch,
// hand sequences for tick timing, long/repeat spacing, active-low and mid-hold reset.

module tb_key_conditioner;
  localparam int DIV = 4, DB = 4, LNG = 8, REP = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] raw_a = 2'b00;
  logic [1:0] raw_b = 2'b11;
  logic       tick_a, tick_b;
  logic [1:0] lvl_a, dn_a, up_a, lg_a, rp_a;
  logic [1:0] lvl_b, dn_b, up_b, lg_b, rp_b;

  always #5 clock = ~clock;

  key_conditioner #(.NUM_KEYS(2), .SAMPLE_DIV(DIV), .DEBOUNCE_SAMPLES(DB),
    .LONG_SAMPLES(LNG), .REPEAT_SAMPLES(REP), .ACTIVE_LOW(0)) dut_a (
    .clock(clock), .reset(reset), .key_raw(raw_a), .sample_tick(tick_a),
    .key_level(lvl_a), .key_down(dn_a), .key_up(up_a), .key_long(lg_a), .key_repeat(rp_a));

  key_conditioner #(.NUM_KEYS(2), .SAMPLE_DIV(DIV), .DEBOUNCE_SAMPLES(DB),
    .LONG_SAMPLES(LNG), .REPEAT_SAMPLES(REP), .ACTIVE_LOW(1)) dut_b (
    .clock(clock), .reset(reset), .key_raw(raw_b), .sample_tick(tick_b),
    .key_level(lvl_b), .key_down(dn_b), .key_up(up_b), .key_long(lg_b), .key_repeat(rp_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  int c_dn[2], c_up[2], c_lg[2], c_rp[2];
  int first_chg;

  // Runs n clocks, counting pulses per key of the selected DUT, sampled on negedges.
  task automatic run(input int n, input bit al);
    logic [1:0] l0, lv, dn, up, lg, rp;
    l0 = al ? lvl_b : lvl_a;
    first_chg = -1;
    for (int k = 0; k < 2; k++) begin
      c_dn[k] = 0; c_up[k] = 0; c_lg[k] = 0; c_rp[k] = 0;
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      lv = al ? lvl_b : lvl_a;
      dn = al ? dn_b : dn_a;
      up = al ? up_b : up_a;
      lg = al ? lg_b : lg_a;
      rp = al ? rp_b : rp_a;
      for (int k = 0; k < 2; k++) begin
        if (dn[k]) c_dn[k]++;
        if (up[k]) c_up[k]++;
        if (lg[k]) c_lg[k]++;
        if (rp[k]) c_rp[k]++;
      end
      if (first_chg < 0 && lv != l0) first_chg = i;
    end
  endtask

  typedef struct {
    string      name;
    logic [1:0] raw;
    int         cyc;
    logic [1:0] lvl;
    int dn0, dn1, up0, up1, lg0, lg1, rp0, rp1;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, quiet, ft, found, nz;
    int dn_at, lg_at, up_at, first_rp, last_rp, n_dn, n_lg, n_up, n_rp, bad_gap, rp_after_up, k0_act;
    int dn_al, up_al, lg_al;

    tbl[0] = '{"press0",  2'b01, 20, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{"rel0",    2'b00, 30, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{"glitch0", 2'b01, 10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{"idle",    2'b00, 30, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{"both",    2'b11, 20, 2'b11, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{"relboth", 2'b00, 30, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0};

    // Reset state and tick cadence
    repeat (3) @(negedge clock);
    chk("reset_outs_a", int'({tick_a, lvl_a, dn_a, up_a, lg_a, rp_a}), 0);
    chk("reset_outs_b", int'({tick_b, lvl_b, dn_b, up_b, lg_b, rp_b}), 0);
    reset = 1'b1;
    bad = 0; quiet = 0; ft = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (tick_a !== ((i % 4) == 3)) bad++;
      if (ft < 0 && tick_a) ft = i;
      if ({lvl_a, dn_a, up_a, lg_a, rp_a, lvl_b, dn_b, up_b, lg_b, rp_b} != '0) quiet++;
    end
    chk("first_tick", ft, 3);
    chk("tick_pattern", bad, 0);
    chk("idle_quiet", quiet, 0);

    // Table of press/release/glitch vectors
    for (int v = 0; v < 6; v++) begin
      raw_a = tbl[v].raw;
      run(tbl[v].cyc, 1'b0);
      chk({tbl[v].name, ".lvl"}, int'(lvl_a), int'(tbl[v].lvl));
      chk({tbl[v].name, ".dn0"}, c_dn[0], tbl[v].dn0);
      chk({tbl[v].name, ".dn1"}, c_dn[1], tbl[v].dn1);
      chk({tbl[v].name, ".up0"}, c_up[0], tbl[v].up0);
      chk({tbl[v].name, ".up1"}, c_up[1], tbl[v].up1);
      chk({tbl[v].name, ".lg0"}, c_lg[0], tbl[v].lg0);
      chk({tbl[v].name, ".lg1"}, c_lg[1], tbl[v].lg1);
      chk({tbl[v].name, ".rp0"}, c_rp[0], tbl[v].rp0);
      chk({tbl[v].name, ".rp1"}, c_rp[1], tbl[v].rp1);
      if (v == 0) chk_rng("press_latency", first_chg, 15, 18);
    end

    // Long hold on key 1: long 8 ticks after down, repeat every 3 ticks, stop on release
    dn_at = -1; lg_at = -1; up_at = -1; first_rp = -1; last_rp = -1;
    n_dn = 0; n_lg = 0; n_up = 0; n_rp = 0; bad_gap = 0; rp_after_up = 0; k0_act = 0;
    raw_a = 2'b10;
    for (int i = 1; i <= 370; i++) begin
      if (i == 331) raw_a = 2'b00;
      @(negedge clock);
      if (dn_a[1]) begin n_dn++; if (dn_at < 0) dn_at = i; end
      if (lg_a[1]) begin n_lg++; if (lg_at < 0) lg_at = i; end
      if (up_a[1]) begin n_up++; if (up_at < 0) up_at = i; end
      if (rp_a[1]) begin
        n_rp++;
        if (up_at >= 0) rp_after_up++;
        if (first_rp < 0) first_rp = i;
        else if (i - last_rp != REP * DIV) bad_gap++;
        last_rp = i;
      end
      if ({dn_a[0], up_a[0], lg_a[0], rp_a[0], lvl_a[0]} != '0) k0_act++;
    end
    chk("hold.dn_count", n_dn, 1);
    chk("hold.long_count", n_lg, 1);
    chk("hold.long_delay", lg_at - dn_at, LNG * DIV);
    chk("hold.first_rpt", first_rp - lg_at, REP * DIV);
    chk("hold.rpt_gaps_bad", bad_gap, 0);
    chk("hold.rpt_ge20", int'(n_rp >= 20), 1);
    chk("hold.up_count", n_up, 1);
    chk("hold.rpt_after_up", rp_after_up, 0);
    chk("hold.key0_quiet", k0_act, 0);
    chk("hold.lvl_end", int'(lvl_a), 0);

    // Active-low instance: pull bit 0 low for 30 clocks
    raw_b = 2'b10;
    run(30, 1'b1);
    chk("al.lvl_pressed", int'(lvl_b), 1);
    chk_rng("al.press_latency", first_chg, 15, 18);
    dn_al = c_dn[0] + c_dn[1]; up_al = c_up[0] + c_up[1]; lg_al = c_lg[0] + c_lg[1];
    raw_b = 2'b11;
    run(40, 1'b1);
    dn_al += c_dn[0] + c_dn[1]; up_al += c_up[0] + c_up[1]; lg_al += c_lg[0] + c_lg[1];
    chk("al.lvl_released", int'(lvl_b), 0);
    chk("al.dn_total", dn_al, 1);
    chk("al.up_total", up_al, 1);
    chk("al.long_total", lg_al, 0);
    chk("al.up0", c_up[0], 1);

    // Reset in the middle of a long hold on key 0
    raw_a = 2'b01;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (lg_a[0]) begin found = 1; break; end
    end
    chk("rst.long_before_reset", found, 1);
    reset = 1'b0;
    nz = 0;
    repeat (5) begin
      @(negedge clock);
      if ({tick_a, lvl_a, dn_a, up_a, lg_a, rp_a} != '0) nz++;
    end
    chk("rst.outs_zero", nz, 0);
    reset = 1'b1;
    run(40, 1'b0);
    chk("rst.redown_latency", first_chg, 16);
    chk("rst.dn0", c_dn[0], 1);
    chk("rst.up0", c_up[0], 0);
    chk("rst.lvl", int'(lvl_a), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
